count_snapshot_fifo: RTL and testbench

Downstream consumer of the 16-bit free-running event counter. It samples `count` on a `trigger` pulse and buffers each sample in a small show-ahead FIFO. Samples are presented to a reader over a valid/ready handshake. The block sits between the counter and the status/readback logic, so software or a test bench can collect timestamps without stalling the counter.

---
 rtl/count_snap_pkg.sv | 13 +
 rtl/count_snap_mem.sv | 28 ++
 rtl/count_snapshot_fifo.sv | 116 +++++++++++
 tb/tb_count_snapshot_fifo.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/count_snap_pkg.sv
// Shared sizing constants and types for the count snapshot FIFO.
// Optional delta storage is enabled with `COUNT_SNAP_DELTA_EN (see count_snapshot_fifo).
package count_snap_pkg;

    localparam int unsigned SNAP_WIDTH = 16;
    localparam int unsigned SNAP_DEPTH = 4;
    localparam int unsigned SNAP_PTR_W = $clog2(SNAP_DEPTH) + 1;

    typedef logic [SNAP_WIDTH-1:0] snap_t;
    typedef logic [SNAP_PTR_W-1:0] ptr_t;
    typedef logic [SNAP_PTR_W-1:0] level_t;

endpackage

// File: rtl/count_snap_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous read port.
// No reset; entry validity is tracked by the FIFO pointers.
module count_snap_mem
    import count_snap_pkg::*;
#(
    parameter int unsigned WIDTH = SNAP_WIDTH,
    parameter int unsigned DEPTH = SNAP_DEPTH,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/count_snapshot_fifo.sv
// Samples the event counter on trigger into a show-ahead FIFO read over valid/ready.
// Define COUNT_SNAP_DELTA_EN to store count deltas since the previous accepted sample.
module count_snapshot_fifo
    import count_snap_pkg::*;
#(
    parameter int unsigned WIDTH = SNAP_WIDTH,
    parameter int unsigned DEPTH = SNAP_DEPTH
) (
    input  logic                     clock,
    input  logic                     resetN,
    input  logic [WIDTH-1:0]         count,
    input  logic                     trigger,
    input  logic                     clear,
    output logic [WIDTH-1:0]         snap_data,
    output logic                     snap_valid,
    input  logic                     snap_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     dropped
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic             dropped_q, dropped_d;
    logic             empty, pop, push;
    logic [WIDTH-1:0] wr_data, rd_data;

    always_comb begin
        empty = (wr_ptr_q == rd_ptr_q);
        full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pop   = !empty && snap_ready;
        // A full FIFO still accepts a push when the head leaves on the same edge.
        push  = trigger && (!full || pop);
    end

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        dropped_d = dropped_q;
        if (clear) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            dropped_d = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (trigger && !push) begin
                dropped_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            dropped_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            dropped_q <= dropped_d;
        end
    end

`ifdef COUNT_SNAP_DELTA_EN
    logic [WIDTH-1:0] base_q, base_d;

    always_comb begin
        base_d = base_q;
        if (clear) begin
            base_d = '0;
        end else if (push) begin
            base_d = count;
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            base_q <= '0;
        end else begin
            base_q <= base_d;
        end
    end

    assign wr_data = count - base_q;
`else
    assign wr_data = count;
`endif

    count_snap_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clock (clock),
        .we    (push && !clear),
        .waddr (wr_ptr_q[AW-1:0]),
        .wdata (wr_data),
        .raddr (rd_ptr_q[AW-1:0]),
        .rdata (rd_data)
    );

    assign level      = wr_ptr_q - rd_ptr_q;
    assign snap_valid = !empty;
    // The memory has no reset, so mask the head to keep snap_data at 0 while empty.
    assign snap_data  = snap_valid ? rd_data : '0;
    assign dropped    = dropped_q;

endmodule

// File: tb/tb_count_snapshot_fifo.sv
// Directed bench for count_snapshot_fifo: a scoreboard queue of expected samples is checked
// by a monitor on every accepted pop; status outputs are checked after each edge.
module tb_count_snapshot_fifo;
    import count_snap_pkg::*;

    localparam int unsigned DEPTH = SNAP_DEPTH;

    logic        clock = 1'b0;
    logic        resetN;
    snap_t       count;
    logic        trigger, clear, snap_ready;
    snap_t       snap_data;
    logic        snap_valid, full, dropped;
    level_t      level;

    int          n_checks = 0;
    int          n_fail   = 0;
    snap_t       exp_q[$];
    int          m_level;
    bit          m_dropped;
    snap_t       m_base;

    count_snapshot_fifo dut (
        .clock      (clock),
        .resetN     (resetN),
        .count      (count),
        .trigger    (trigger),
        .clear      (clear),
        .snap_data  (snap_data),
        .snap_valid (snap_valid),
        .snap_ready (snap_ready),
        .level      (level),
        .full       (full),
        .dropped    (dropped)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // A pop happens at the next rising edge; inputs are stable at the falling edge.
    always @(negedge clock) begin
        if (resetN === 1'b1 && snap_valid === 1'b1 && snap_ready === 1'b1 && clear === 1'b0) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL head: got %0h expected no entry at %0t", snap_data, $time);
            end else begin
                chk("head", snap_data, exp_q.pop_front());
            end
        end
    end

    task automatic status(input string tag);
        chk({tag, " level"}, 32'(level), 32'(m_level));
        chk({tag, " full"}, 32'(full), 32'(m_level == DEPTH));
        chk({tag, " valid"}, 32'(snap_valid), 32'(m_level != 0));
        chk({tag, " dropped"}, 32'(dropped), 32'(m_dropped));
    endtask

    task automatic cycle(input bit trg, input snap_t cnt, input bit rdy, input bit clr);
        bit pop_m, acc;
        trigger    = trg;
        count      = cnt;
        snap_ready = rdy;
        clear      = clr;
        if (clr) begin
            exp_q.delete();
            m_level   = 0;
            m_dropped = 1'b0;
            m_base    = '0;
        end else begin
            pop_m = rdy && (m_level > 0);
            acc   = trg && ((m_level < DEPTH) || pop_m);
            if (acc) begin
`ifdef COUNT_SNAP_DELTA_EN
                exp_q.push_back(cnt - m_base);
                m_base = cnt;
`else
                exp_q.push_back(cnt);
`endif
                m_level++;
            end
            if (pop_m) m_level--;
            if (trg && !acc) m_dropped = 1'b1;
        end
        @(posedge clock);
        #1;
        trigger    = 1'b0;
        clear      = 1'b0;
        snap_ready = 1'b0;
        status("cyc");
    endtask

    initial begin
        resetN     = 1'b0;
        trigger    = 1'b0;
        clear      = 1'b0;
        snap_ready = 1'b0;
        count      = '0;
        m_level    = 0;
        m_dropped  = 1'b0;
        m_base     = '0;

        #2;
        chk("reset valid", 32'(snap_valid), 0);
        chk("reset level", 32'(level), 0);
        chk("reset full", 32'(full), 0);
        chk("reset dropped", 32'(dropped), 0);
        chk("reset data", 32'(snap_data), 0);
        #10 resetN = 1'b1;

        // Single capture then read
        cycle(1'b1, 16'd5, 1'b0, 1'b0);
        chk("t1 data", 32'(snap_data), 32'd5);
        chk("t1 level", 32'(level), 32'd1);
        cycle(1'b0, 16'd0, 1'b1, 1'b0);
        chk("t1 empty", 32'(snap_valid), 0);

        // Overflow: five triggers into four entries
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, snap_t'(10 + i), 1'b0, 1'b0);
            if (i == 3) begin
                chk("t2 full", 32'(full), 32'd1);
                chk("t2 no drop yet", 32'(dropped), 0);
            end
            if (i == 4) chk("t2 dropped", 32'(dropped), 32'd1);
        end
        for (int i = 0; i < 4; i++) cycle(1'b0, 16'd0, 1'b1, 1'b0);
        chk("t2 sticky", 32'(dropped), 32'd1);
        cycle(1'b0, 16'd0, 1'b0, 1'b1);
        chk("t2 clear dropped", 32'(dropped), 0);

        // Full with simultaneous push and pop
        for (int i = 16; i < 20; i++) cycle(1'b1, snap_t'(i), 1'b0, 1'b0);
        cycle(1'b1, 16'd20, 1'b1, 1'b0);
        chk("t3 level", 32'(level), 32'd4);
        chk("t3 dropped", 32'(dropped), 0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 16'd0, 1'b1, 1'b0);

        // Clear beats trigger and pop
        cycle(1'b1, 16'd40, 1'b0, 1'b0);
        cycle(1'b1, 16'd41, 1'b0, 1'b0);
        cycle(1'b1, 16'd42, 1'b1, 1'b1);
        chk("t4 level", 32'(level), 0);
        chk("t4 valid", 32'(snap_valid), 0);
        chk("t4 dropped", 32'(dropped), 0);

        // Wrap of the delta subtraction
        cycle(1'b1, 16'hFFF0, 1'b0, 1'b0);
        cycle(1'b1, 16'h0010, 1'b0, 1'b0);
        chk("t5 first", 32'(snap_data), 32'h0000FFF0);
        cycle(1'b0, 16'd0, 1'b1, 1'b0);
`ifdef COUNT_SNAP_DELTA_EN
        chk("t5 second", 32'(snap_data), 32'h00000020);
`else
        chk("t5 second", 32'(snap_data), 32'h00000010);
`endif
        cycle(1'b0, 16'd0, 1'b1, 1'b0);

        // Asynchronous reset mid-cycle with 3 entries stored
        for (int i = 1; i < 4; i++) cycle(1'b1, snap_t'(i), 1'b0, 1'b0);
        chk("t6 pre level", 32'(level), 32'd3);
        #3 resetN = 1'b0;
        #1;
        chk("t6 async level", 32'(level), 0);
        chk("t6 async valid", 32'(snap_valid), 0);
        chk("t6 async full", 32'(full), 0);
        exp_q.delete();
        m_level   = 0;
        m_dropped = 1'b0;
        m_base    = '0;
        #2 resetN = 1'b1;
        cycle(1'b1, 16'd7, 1'b0, 1'b0);
        chk("t6 capture", 32'(snap_data), 32'd7);
        cycle(1'b0, 16'd0, 1'b1, 1'b0);

        chk("scoreboard drained", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
